buzzer_tone_gen: RTL and testbench



---
 rtl/buzzer_tone_gen.sv | 137 +++++++++++++
 tb/tb_buzzer_tone_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_tone_gen.sv
// rtl/buzzer_tone_gen.sv - square-wave buzzer driver with a silent articulation gap at every note start
module buzzer_tone_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned GAP_CYCLES  = 2_000_000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    input  logic       note_start,
    output logic       speaker,
    output logic       sounding
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    // Mid-octave half periods in clock cycles, truncated.
    localparam logic [31:0] HALF_1 = CLK_FREQ_HZ / (2 * 262);
    localparam logic [31:0] HALF_2 = CLK_FREQ_HZ / (2 * 294);
    localparam logic [31:0] HALF_3 = CLK_FREQ_HZ / (2 * 330);
    localparam logic [31:0] HALF_4 = CLK_FREQ_HZ / (2 * 349);
    localparam logic [31:0] HALF_5 = CLK_FREQ_HZ / (2 * 392);
    localparam logic [31:0] HALF_6 = CLK_FREQ_HZ / (2 * 440);
    localparam logic [31:0] HALF_7 = CLK_FREQ_HZ / (2 * 494);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        TONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       note_q;
    logic [1:0]       octave_q;

    logic             playable;
    logic             change;
    logic             restart;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] half;

    always_comb begin
        playable = enable && (note_in >= 4'd1) && (note_in <= 4'd7);
        change   = playable && ({note_in, octave_in} != {note_q, octave_q});
        restart  = note_start || change;
    end

    // Pitch always comes from the latched note so input glitches cannot bend a tone.
    always_comb begin
        base = '0;
        case (note_q)
            4'd1:    base = HALF_1[CNT_W-1:0];
            4'd2:    base = HALF_2[CNT_W-1:0];
            4'd3:    base = HALF_3[CNT_W-1:0];
            4'd4:    base = HALF_4[CNT_W-1:0];
            4'd5:    base = HALF_5[CNT_W-1:0];
            4'd6:    base = HALF_6[CNT_W-1:0];
            4'd7:    base = HALF_7[CNT_W-1:0];
            default: base = '0;
        endcase
    end

    always_comb begin
        half = base;
        case (octave_q)
            2'd0:    half = base << 1;
            2'd2:    half = base >> 1;
            default: half = base;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            note_q   <= '0;
            octave_q <= '0;
            speaker  <= 1'b0;
            sounding <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    speaker  <= 1'b0;
                    sounding <= 1'b0;
                    if (playable) begin
                        note_q   <= note_in;
                        octave_q <= octave_in;
                        gap_cnt  <= GAP_LOAD;
                        state    <= GAP;
                    end
                end
                GAP, TONE: begin
                    if (!playable) begin
                        state    <= IDLE;
                        speaker  <= 1'b0;
                        sounding <= 1'b0;
                    end else if (restart) begin
                        // A strobe coinciding with a code change still yields a single gap.
                        note_q   <= note_in;
                        octave_q <= octave_in;
                        gap_cnt  <= GAP_LOAD;
                        state    <= GAP;
                        speaker  <= 1'b0;
                        sounding <= 1'b0;
                    end else if (state == GAP) begin
                        if (gap_cnt == '0) begin
                            cnt      <= '0;
                            state    <= TONE;
                            sounding <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end else begin
                        if (cnt == half - 1'b1) begin
                            speaker <= ~speaker;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    speaker  <= 1'b0;
                    sounding <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// tb/tb_buzzer_tone_gen.sv - self-checking bench for buzzer_tone_gen
module tb_buzzer_tone_gen;

    // Scaled clock keeps half periods in the hundreds of cycles.
    localparam int TB_CLK = 100_000;
    localparam int GAP    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       note_start;
    logic       speaker;
    logic       sounding;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    buzzer_tone_gen #(
        .CLK_FREQ_HZ(TB_CLK),
        .GAP_CYCLES (GAP),
        .CNT_W      (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .note_in   (note_in),
        .octave_in (octave_in),
        .note_start(note_start),
        .speaker   (speaker),
        .sounding  (sounding)
    );

    function automatic int exp_half(input logic [3:0] n, input logic [1:0] o);
        int f[7] = '{262, 294, 330, 349, 392, 440, 494};
        int b;
        if (n < 4'd1 || n > 4'd7) return 0;
        b = TB_CLK / (2 * f[int'(n) - 1]);
        case (o)
            2'd0:    return b * 2;
            2'd2:    return b / 2;
            default: return b;
        endcase
    endfunction

    // Reference: a note is either absent, waiting out its gap, or t cycles into its tone.
    logic       pl;
    logic       m_active;
    logic       m_in_tone;
    logic [3:0] m_note;
    logic [1:0] m_oct;
    int         m_gap;
    int         m_t;

    assign pl = enable && (note_in >= 4'd1) && (note_in <= 4'd7);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active  <= 1'b0;
            m_in_tone <= 1'b0;
            m_note    <= 4'd0;
            m_oct     <= 2'd0;
            m_gap     <= 0;
            m_t       <= 0;
        end else if (!m_active) begin
            if (pl) begin
                m_active  <= 1'b1;
                m_note    <= note_in;
                m_oct     <= octave_in;
                m_gap     <= GAP;
                m_in_tone <= 1'b0;
            end
        end else if (!pl) begin
            m_active  <= 1'b0;
            m_in_tone <= 1'b0;
        end else if (note_start || note_in != m_note || octave_in != m_oct) begin
            m_note    <= note_in;
            m_oct     <= octave_in;
            m_gap     <= GAP;
            m_in_tone <= 1'b0;
        end else if (!m_in_tone) begin
            if (m_gap == 1) begin
                m_in_tone <= 1'b1;
                m_t       <= 0;
            end
            m_gap <= m_gap - 1;
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic exp_spk;
        exp_spk = m_in_tone && (((m_t / exp_half(m_note, m_oct)) % 2) == 1);
        vectors++;
        if (speaker !== exp_spk || sounding !== m_in_tone) begin
            miscompares++;
            $display("FAIL model t=%0t: speaker=%b sounding=%b, expected speaker=%b sounding=%b",
                     $time, speaker, sounding, exp_spk, m_in_tone);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_gap(input bit pulse, output int n);
        note_start = pulse;
        n = 0;
        while (n < 64) begin
            tick();
            note_start = 1'b0;
            n++;
            if (sounding) break;
        end
    endtask

    task automatic wait_spk(input logic lvl, output int n);
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if (speaker == lvl) break;
        end
    endtask

    task automatic play(input string name, input int gap_exp, input int half_exp);
        int n;
        run_gap(1'b0, n);
        check({name, "_gap"}, n, gap_exp);
        wait_spk(1'b1, n);
        check({name, "_rise"}, n, half_exp);
        wait_spk(1'b0, n);
        check({name, "_fall"}, n, half_exp);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] note;
        logic [1:0] oct;
        int         half;
        string      name;
    } vec_t;

    vec_t tv[14];

    initial begin
        int n;
        tv[0]  = '{1'b1, 4'd6,  2'd1, 113, "n6_mid"};
        tv[1]  = '{1'b1, 4'd6,  2'd2,  56, "n6_high"};
        tv[2]  = '{1'b1, 4'd6,  2'd0, 226, "n6_low"};
        tv[3]  = '{1'b1, 4'd6,  2'd3, 113, "n6_oct3"};
        tv[4]  = '{1'b1, 4'd0,  2'd1,   0, "rest"};
        tv[5]  = '{1'b1, 4'd3,  2'd1, 151, "n3_mid"};
        tv[6]  = '{1'b1, 4'd15, 2'd1,   0, "end_mark"};
        tv[7]  = '{1'b1, 4'd1,  2'd1, 190, "n1_mid"};
        tv[8]  = '{1'b1, 4'd9,  2'd2,   0, "invalid9"};
        tv[9]  = '{1'b1, 4'd7,  2'd2,  50, "n7_high"};
        tv[10] = '{1'b0, 4'd4,  2'd1,   0, "muted"};
        tv[11] = '{1'b1, 4'd4,  2'd0, 286, "n4_low"};
        tv[12] = '{1'b1, 4'd5,  2'd3, 127, "n5_oct3"};
        tv[13] = '{1'b1, 4'd2,  2'd1, 170, "n2_mid"};

        reset      = 1'b1;
        enable     = 1'b0;
        note_in    = 4'd0;
        octave_in  = 2'd0;
        note_start = 1'b0;
        tick();
        check("reset_speaker", speaker, 0);
        check("reset_sounding", sounding, 0);
        enable    = 1'b1;
        note_in   = 4'd6;
        octave_in = 2'd1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            enable    = tv[i].en;
            note_in   = tv[i].note;
            octave_in = tv[i].oct;
            if (tv[i].half == 0) begin
                tick();
                check({tv[i].name, "_silent"}, {speaker, sounding}, 0);
                repeat (3) tick();
            end else begin
                play(tv[i].name, GAP + 1, tv[i].half);
            end
        end

        // Repeated identical note: strobe retriggers the gap.
        note_in = 4'd1;
        octave_in = 2'd1;
        play("retrig_setup", GAP + 1, 190);
        wait_spk(1'b1, n);
        run_gap(1'b1, n);
        check("retrig_gap", n, GAP + 1);
        wait_spk(1'b1, n);
        check("retrig_rise", n, 190);

        // Strobe plus change in one cycle, then a strobe mid-gap.
        note_in = 4'd7;
        play("n7_setup", GAP + 1, 101);
        note_in = 4'd5;
        run_gap(1'b1, n);
        check("strobe_change_gap", n, GAP + 1);
        wait_spk(1'b1, n);
        check("strobe_change_rise", n, 127);
        note_in = 4'd7;
        note_start = 1'b1;
        tick();
        note_start = 1'b0;
        tick();
        run_gap(1'b1, n);
        check("midgap_restart", n, GAP + 1);

        // Asynchronous reset while the speaker is high.
        wait_spk(1'b1, n);
        check("pre_reset_high", speaker, 1);
        reset = 1'b1;
        #1;
        check("async_reset_speaker", speaker, 0);
        tick();
        reset = 1'b0;
        run_gap(1'b0, n);
        check("post_reset_gap", n, GAP + 1);

        // Mute mid-tone, then unmute on a new note.
        wait_spk(1'b1, n);
        enable = 1'b0;
        tick();
        check("mute_silent", {speaker, sounding}, 0);
        enable = 1'b1;
        note_in = 4'd2;
        octave_in = 2'd1;
        play("unmute_n2", GAP + 1, 170);

        // Randomized segments, judged by the reference model on every cycle.
        for (int s = 0; s < 40; s++) begin
            enable     = ($urandom_range(0, 7) != 0);
            note_in    = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15));
            octave_in  = 2'($urandom_range(0, 3));
            note_start = ($urandom_range(0, 9) < 3);
            tick();
            note_start = 1'b0;
            repeat ($urandom_range(1, 400)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
